// File: rtl/router_pkg.sv
// Shared router constants: default packet width, position of the VC bit
// in [0:N-1] packet ordering, and the number of virtual channels.
package router_pkg;
    localparam int PACKET_WIDTH_DEFAULT = 64;
    localparam int VC_BIT               = 0;
    localparam int NUM_VC               = 2;
endpackage

// File: rtl/vc_buffer.sv
// One-entry packet register with a full flag. The full flag is the only
// validity indicator; the data word is cleared only by reset.
module vc_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             clr,
    input  logic [0:WIDTH-1] din,
    output logic [0:WIDTH-1] dout,
    output logic             full
);

    // wr and clr never coincide: the port drives them from opposite polarity phases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
            full <= 1'b0;
        end else if (wr) begin
            dout <= din;
            full <= 1'b1;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/router_pe_port.sv
// Router-side PE port: per-VC ingress/egress one-entry buffers, alternated between
// the NIC link and the crossbar by a toggling polarity. Optional macro: PE_PORT_VC_CHECK_EN.
module router_pe_port
    import router_pkg::*;
#(
    parameter int PACKET_WIDTH = PACKET_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  polarity,
    input  logic                  pe_si,
    output logic                  pe_ri,
    input  logic [0:PACKET_WIDTH-1] pe_di,
    output logic                  pe_so,
    input  logic                  pe_ro,
    output logic [0:PACKET_WIDTH-1] pe_do,
    output logic                  xb_req,
    output logic [0:PACKET_WIDTH-1] xb_dout,
    input  logic                  xb_gnt,
    input  logic                  xb_si,
    output logic                  xb_ri,
    input  logic [0:PACKET_WIDTH-1] xb_din,
    output logic                  err_vc
);

    logic                    p;
    logic [NUM_VC-1:0]       ing_full;
    logic [NUM_VC-1:0]       egr_full;
    logic [NUM_VC-1:0]       ing_wr;
    logic [NUM_VC-1:0]       ing_clr;
    logic [NUM_VC-1:0]       egr_wr;
    logic [NUM_VC-1:0]       egr_clr;
    logic [0:PACKET_WIDTH-1] ing_q [NUM_VC];
    logic [0:PACKET_WIDTH-1] egr_q [NUM_VC];
    logic                    ing_hs;
    logic                    vc_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) p <= 1'b0;
        else        p <= ~p;
    end

    assign polarity = p;

    // Handshakes: a transfer happens on a rising edge where the sender's strobe
    // (pe_si, xb_si, pe_so, xb_req) and the receiver's ready (pe_ri, xb_ri, pe_ro,
    // xb_gnt) are both high; a strobe without ready is ignored and changes nothing.
    // Link side uses VC p, crossbar side uses VC ~p, so no buffer sees both at once.
    assign pe_ri   = ~ing_full[p];
    assign xb_req  = ing_full[~p];
    assign xb_dout = ing_q[~p];
    assign xb_ri   = ~egr_full[~p];
    assign pe_so   = egr_full[p];
    assign pe_do   = egr_q[p];

    assign ing_hs = pe_si & pe_ri;

`ifdef PE_PORT_VC_CHECK_EN
    logic err_q;

    // A packet tagged for the wrong VC completes its handshake but is dropped.
    assign vc_ok = (pe_di[VC_BIT] == p);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               err_q <= 1'b0;
        else if (ing_hs && !vc_ok) err_q <= 1'b1;
    end

    assign err_vc = err_q;
`else
    assign vc_ok  = 1'b1;
    assign err_vc = 1'b0;
`endif

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        localparam logic VC = 1'(v);

        assign ing_wr[v]  = ing_hs & vc_ok & (p == VC);
        assign ing_clr[v] = xb_req & xb_gnt & (p != VC);
        assign egr_wr[v]  = xb_si & xb_ri & (p != VC);
        assign egr_clr[v] = pe_so & pe_ro & (p == VC);

        vc_buffer #(.WIDTH(PACKET_WIDTH)) u_ing (
            .clk  (clk),
            .reset(reset),
            .wr   (ing_wr[v]),
            .clr  (ing_clr[v]),
            .din  (pe_di),
            .dout (ing_q[v]),
            .full (ing_full[v])
        );

        vc_buffer #(.WIDTH(PACKET_WIDTH)) u_egr (
            .clk  (clk),
            .reset(reset),
            .wr   (egr_wr[v]),
            .clr  (egr_clr[v]),
            .din  (xb_din),
            .dout (egr_q[v]),
            .full (egr_full[v])
        );
    end

endmodule

// File: tb/tb_router_pe_port.sv
// Directed bench for router_pe_port: per-cycle vector table plus hand sequences
// for VC checking (PE_PORT_VC_CHECK_EN) and reset with all buffers full.
module tb_router_pe_port;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        pe_si;
    logic        pe_ri;
    logic [63:0] pe_di;
    logic        pe_so;
    logic        pe_ro;
    logic [63:0] pe_do;
    logic        xb_req;
    logic [63:0] xb_dout;
    logic        xb_gnt;
    logic        xb_si;
    logic        xb_ri;
    logic [63:0] xb_din;
    logic        err_vc;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic        pe_si;
        logic [63:0] pe_di;
        logic        xb_gnt;
        logic        xb_si;
        logic [63:0] xb_din;
        logic        pe_ro;
        logic        e_pol;
        logic        e_pe_ri;
        logic        e_xb_req;
        logic [63:0] e_xb_dout;
        logic        e_pe_so;
        logic [63:0] e_pe_do;
        logic        e_xb_ri;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vec [NVEC];

    router_pe_port #(.PACKET_WIDTH(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .polarity(polarity),
        .pe_si   (pe_si),
        .pe_ri   (pe_ri),
        .pe_di   (pe_di),
        .pe_so   (pe_so),
        .pe_ro   (pe_ro),
        .pe_do   (pe_do),
        .xb_req  (xb_req),
        .xb_dout (xb_dout),
        .xb_gnt  (xb_gnt),
        .xb_si   (xb_si),
        .xb_ri   (xb_ri),
        .xb_din  (xb_din),
        .err_vc  (err_vc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic si, logic [63:0] di, logic gnt, logic xsi,
                                logic [63:0] xdin, logic ro, logic pol, logic ri,
                                logic req, logic [63:0] dout, logic so,
                                logic [63:0] pdo, logic xri);
        vec_t v;
        v.pe_si = si;   v.pe_di = di;     v.xb_gnt = gnt;
        v.xb_si = xsi;  v.xb_din = xdin;  v.pe_ro = ro;
        v.e_pol = pol;  v.e_pe_ri = ri;   v.e_xb_req = req;
        v.e_xb_dout = dout; v.e_pe_so = so; v.e_pe_do = pdo; v.e_xb_ri = xri;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        pe_si  = 1'b0;
        pe_di  = '0;
        pe_ro  = 1'b0;
        xb_gnt = 1'b0;
        xb_si  = 1'b0;
        xb_din = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " polarity"}, 64'(polarity), 64'd0);
        chk({tag, " pe_ri"},    64'(pe_ri),    64'd1);
        chk({tag, " xb_ri"},    64'(xb_ri),    64'd1);
        chk({tag, " pe_so"},    64'(pe_so),    64'd0);
        chk({tag, " xb_req"},   64'(xb_req),   64'd0);
        chk({tag, " pe_do"},    pe_do,         64'd0);
        chk({tag, " xb_dout"},  xb_dout,       64'd0);
        chk({tag, " err_vc"},   64'(err_vc),   64'd0);
    endtask

    // Leaves the bench at a falling edge with reset just released, polarity 0.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values(tag);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();

        //            si  pe_di                  gnt xsi xb_din                 ro  pol ri req xb_dout                so  pe_do                  xri
        vec[0]  = mk(1, 64'h0000_0000_0000_00A5, 0, 0, 64'h0,                 0,  0,  1, 0, 64'h0,                 0, 64'h0,                 1);
        vec[1]  = mk(0, 64'h0,                   1, 0, 64'h0,                 0,  1,  1, 1, 64'h0000_0000_0000_00A5, 0, 64'h0,               1);
        vec[2]  = mk(0, 64'h0,                   0, 1, 64'h8000_0000_0000_1234, 0, 0, 1, 0, 64'h0,                 0, 64'h0,                 1);
        vec[3]  = mk(0, 64'h0,                   0, 0, 64'h0,                 0,  1,  1, 0, 64'h0,                 1, 64'h8000_0000_0000_1234, 1);
        vec[4]  = mk(0, 64'h0,                   0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 64'h0,                 0, 64'h0,                 0);
        vec[5]  = mk(0, 64'h0,                   0, 0, 64'h0,                 1,  1,  1, 0, 64'h0,                 1, 64'h8000_0000_0000_1234, 1);
        vec[6]  = mk(1, 64'h0,                   0, 0, 64'h0,                 0,  0,  1, 0, 64'h0,                 0, 64'h0,                 1);
        vec[7]  = mk(0, 64'h0,                   0, 0, 64'h0,                 0,  1,  1, 1, 64'h0,                 0, 64'h0,                 1);
        vec[8]  = mk(1, 64'h0000_0000_0000_0077, 0, 0, 64'h0,                 0,  0,  0, 0, 64'h0,                 0, 64'h0,                 1);
        vec[9]  = mk(0, 64'h0,                   1, 0, 64'h0,                 0,  1,  1, 1, 64'h0,                 0, 64'h0,                 1);
        vec[10] = mk(0, 64'h0,                   1, 0, 64'h0,                 1,  0,  1, 0, 64'h0,                 0, 64'h0,                 1);
        vec[11] = mk(1, 64'h8000_0000_0000_0BCD, 0, 0, 64'h0,                 0,  1,  1, 0, 64'h0,                 0, 64'h0,                 1);
        vec[12] = mk(0, 64'h0,                   1, 0, 64'h0,                 0,  0,  1, 1, 64'h8000_0000_0000_0BCD, 0, 64'h0,               1);
        vec[13] = mk(0, 64'h0,                   0, 0, 64'h0,                 0,  1,  1, 0, 64'h0,                 0, 64'h0,                 1);

        apply_reset("rst0");

        // vector table: check outputs of this cycle, then drive its inputs
        for (int i = 0; i < NVEC; i++) begin
            chk($sformatf("v%0d polarity", i), 64'(polarity), 64'(vec[i].e_pol));
            chk($sformatf("v%0d pe_ri", i),    64'(pe_ri),    64'(vec[i].e_pe_ri));
            chk($sformatf("v%0d xb_req", i),   64'(xb_req),   64'(vec[i].e_xb_req));
            chk($sformatf("v%0d pe_so", i),    64'(pe_so),    64'(vec[i].e_pe_so));
            chk($sformatf("v%0d xb_ri", i),    64'(xb_ri),    64'(vec[i].e_xb_ri));
            chk($sformatf("v%0d err_vc", i),   64'(err_vc),   64'd0);
            if (vec[i].e_xb_req) chk($sformatf("v%0d xb_dout", i), xb_dout, vec[i].e_xb_dout);
            if (vec[i].e_pe_so)  chk($sformatf("v%0d pe_do", i),   pe_do,   vec[i].e_pe_do);
            // scoreboard: accepted ingress packets must leave in order on a grant
            if (vec[i].pe_si && vec[i].e_pe_ri) exp_q.push_back(vec[i].pe_di);
            if (vec[i].xb_gnt && vec[i].e_xb_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d sb_empty: got grant with no expected packet", i);
                end else begin
                    chk($sformatf("v%0d sb_pkt", i), xb_dout, exp_q.pop_front());
                end
            end
            pe_si  = vec[i].pe_si;
            pe_di  = vec[i].pe_di;
            xb_gnt = vec[i].xb_gnt;
            xb_si  = vec[i].xb_si;
            xb_din = vec[i].xb_din;
            pe_ro  = vec[i].pe_ro;
            @(negedge clk);
        end
        drive_idle();
        chk("sb_left", 64'(exp_q.size()), 64'd0);

        // VC tag mismatch: packet tagged VC1 offered while polarity is 0
        apply_reset("rst1");
        chk("vc p0", 64'(polarity), 64'd0);
        pe_si = 1'b1;
        pe_di = 64'h8000_0000_0000_0001;
        @(negedge clk);
        drive_idle();
`ifdef PE_PORT_VC_CHECK_EN
        chk("vc xb_req", 64'(xb_req), 64'd0);
        chk("vc err_vc", 64'(err_vc), 64'd1);
        @(negedge clk);
        chk("vc pe_ri", 64'(pe_ri), 64'd1);
        repeat (3) @(negedge clk);
        chk("vc err_sticky", 64'(err_vc), 64'd1);
`else
        chk("vc xb_req", 64'(xb_req), 64'd1);
        chk("vc xb_dout", xb_dout, 64'h8000_0000_0000_0001);
        chk("vc err_vc", 64'(err_vc), 64'd0);
        @(negedge clk);
        chk("vc pe_ri", 64'(pe_ri), 64'd0);
        repeat (3) @(negedge clk);
        chk("vc err_sticky", 64'(err_vc), 64'd0);
`endif

        // fill all four buffers, then reset asynchronously mid-cycle
        apply_reset("rst2");
        pe_si = 1'b1; pe_di = 64'h0000_0000_0000_0011;
        xb_si = 1'b1; xb_din = 64'h0000_0000_0000_0022;
        @(negedge clk);
        pe_si = 1'b1; pe_di = 64'h8000_0000_0000_0033;
        xb_si = 1'b1; xb_din = 64'h0000_0000_0000_0044;
        @(negedge clk);
        drive_idle();
        chk("full pe_ri",   64'(pe_ri),  64'd0);
        chk("full xb_req",  64'(xb_req), 64'd1);
        chk("full xb_dout", xb_dout,     64'h8000_0000_0000_0033);
        chk("full pe_so",   64'(pe_so),  64'd1);
        chk("full pe_do",   pe_do,       64'h0000_0000_0000_0044);
        chk("full xb_ri",   64'(xb_ri),  64'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clk);
        reset = 1'b1;
        chk("post p0", 64'(polarity), 64'd0);
        @(negedge clk);
        chk("post p1",     64'(polarity), 64'd1);
        chk("post xb_req", 64'(xb_req),   64'd0);
        chk("post pe_so",  64'(pe_so),    64'd0);
        chk("post pe_ri",  64'(pe_ri),    64'd1);
        chk("post xb_ri",  64'(xb_ri),    64'd1);
        @(negedge clk);
        chk("post2 pe_ri", 64'(pe_ri),    64'd1);
        chk("post2 xb_ri", 64'(xb_ri),    64'd1);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_pe_port.md
# router_pe_port

Router-side local (processing-element) port that terminates the NIC's network channels: it accepts packets from the NIC's output channel into per-virtual-channel ingress buffers, presents them to the router crossbar, and delivers crossbar packets to the NIC's input channel. It owns the polarity register, which is exported to the NIC and decides which virtual channel (VC) is link-facing and which is crossbar-facing in each cycle. One instance sits in every router, between the crossbar and the attached NIC.

## Interface
- PACKET_WIDTH, 64, packet width in bits; bit 0 (MSB, [0:N-1] ordering) is the VC bit.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- polarity  out  1  current polarity, wired to the NIC's net_polarity.
- pe_si  in  1  NIC send strobe (ingress).
- pe_ri  out  1  ready to NIC (ingress).
- pe_di  in  PACKET_WIDTH  ingress packet from NIC.
- pe_so  out  1  send strobe to NIC (egress).
- pe_ro  in  1  NIC ready (egress).
- pe_do  out  PACKET_WIDTH  egress packet to NIC.
- xb_req  out  1  ingress packet available to crossbar.
- xb_dout  out  PACKET_WIDTH  ingress packet to crossbar.
- xb_gnt  in  1  crossbar consumed xb_dout.
- xb_si  in  1  crossbar send strobe (egress).
- xb_ri  out  1  egress buffer free.
- xb_din  in  PACKET_WIDTH  egress packet from crossbar.
- err_vc  out  1  sticky VC-mismatch flag (see Configuration).

## Operation
- Polarity register p: reset 0, toggles every cycle.
- Link VC = p; internal VC = ~p. Link and crossbar sides never touch the same VC in one cycle.
- Four one-entry buffers: ing[0..1], egr[0..1], each with a full flag.
- Ingress link: pe_ri = ~ing_full[p]; on pe_si & pe_ri, ing[p] <= pe_di, ing_full[p] <= 1.
- Ingress internal: xb_req = ing_full[~p], xb_dout = ing[~p]; on xb_req & xb_gnt, ing_full[~p] <= 0.
- Egress internal: xb_ri = ~egr_full[~p]; on xb_si & xb_ri, egr[~p] <= xb_din, egr_full[~p] <= 1.
- Egress link: pe_so = egr_full[p], pe_do = egr[p]; on pe_so & pe_ro, egr_full[p] <= 0.
- Full flags are the only validity indicator; an all-zero packet is a valid packet.
- pe_si while pe_ri = 0, xb_gnt while xb_req = 0, xb_si while xb_ri = 0: ignored, no state change.

## Timing
- Reset values: polarity 0, all full flags 0, pe_ri 1, pe_so 0, pe_do 0, xb_req 0, xb_dout 0, xb_ri 1, err_vc 0; buffer data cleared to 0.
- All handshake outputs combinational from registered state and p; no combinational path from any input to any output.
- Ingress latency: packet accepted at edge k is on xb_dout with xb_req = 1 in cycle k+1.
- Egress latency: packet written at edge k is on pe_do with pe_so = 1 in cycle k+1.
- Buffer held until consumed; if not consumed, it reappears every second cycle when its VC faces that side again.
- Full buffer refills on the same edge it is freed only from the opposite side's VC alternation, i.e. no same-cycle read/write on one buffer.
- Reset mid-operation: all buffered packets discarded, polarity restarts at 0.

## Configuration
- PE_PORT_VC_CHECK_EN defined: on an ingress handshake, if pe_di[0] != p, the packet is dropped (handshake completes, buffer unchanged) and err_vc sets, sticky until reset.
- Undefined: every accepted packet is stored regardless of pe_di[0]; err_vc tied 0.

## Structure
- Shared package router_pkg: PACKET_WIDTH default, VC_BIT index (0), NUM_VC (2).
- Sub-module vc_buffer: one-entry register plus full flag with write/clear strobes, instantiated four times.

## Test plan
- Reset low for 2 cycles -> pe_ri=1, xb_ri=1, pe_so=0, xb_req=0, polarity=0, then polarity alternates 1,0,1.
- pe_si=1, pe_di=64'h0000_0000_0000_00A5 with p=0 -> next cycle xb_req=1, xb_dout=...A5; xb_gnt=1 -> xb_req=0 thereafter.
- xb_si=1, xb_din=64'h8000_0000_0000_1234 with p=0 -> next cycle pe_so=1, pe_do=8000...1234; pe_ro=0 holds it, pe_so=1 again two cycles later; pe_ro=1 clears.
- Fill ing[0] and withhold xb_gnt -> pe_ri=0 whenever p=0, pe_ri=1 when p=1; a second pe_si at p=0 leaves ing[0] unchanged.
- With PE_PORT_VC_CHECK_EN: pe_di[0]=1 sent at p=0 -> no xb_req, err_vc=1 until reset; without macro -> packet forwarded, err_vc=0.
- Assert reset with all four buffers full -> all full flags 0, outputs at reset values immediately.
